// File: rtl/band_capture.sv
// ---------------------------------------------------------------------------
// band_capture
// Writer counterpart of the band playback blocks. It fills an internal
// MEM_DEPTH x 16 simple dual-port RAM from valid_in strobes during a capture
// and offers registered readback with one cycle of latency at all times.
//
// Ports
//   clk        in   system clock; all logic on the rising edge
//   rst_n      in   asynchronous active-low reset
//   start      in   pulse: begin a capture (from IDLE or DONE)
//   abort      in   pulse: end a capture early (CAPTURE only)
//   sample_in  in   16-bit signed sample
//   valid_in   in   strobe qualifying sample_in
//   rd_addr    in   readback address
//   rd_data    out  registered RAM[rd_addr]; 0 for out-of-range addresses
//   busy       out  high while capturing
//   done       out  high once the buffer is full (sticky until next start)
//   wr_count   out  samples written in the current or last capture
//   peak_abs   out  running max |sample| of the current capture
//                   (present only when BAND_CAPTURE_PEAK_EN is defined)
//
// Configuration macro: BAND_CAPTURE_PEAK_EN
// ---------------------------------------------------------------------------
module band_capture #(
   parameter int MEM_DEPTH  = 4036,
   parameter int ADDR_WIDTH = $clog2(MEM_DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  abort,
   input  logic signed [15:0]    sample_in,
   input  logic                  valid_in,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic signed [15:0]    rd_data,
   output logic                  busy,
   output logic                  done,
   output logic [ADDR_WIDTH:0]   wr_count
`ifdef BAND_CAPTURE_PEAK_EN
   ,
   output logic [15:0]           peak_abs
`endif
);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] CAPTURE = 2'd1;
   localparam logic [1:0] DONE    = 2'd2;

   localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(MEM_DEPTH - 1);
   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
   localparam logic [ADDR_WIDTH:0]   CNT_ONE   = (ADDR_WIDTH + 1)'(1);
   localparam logic [ADDR_WIDTH:0]   DEPTH_CNT = (ADDR_WIDTH + 1)'(MEM_DEPTH);

   logic [15:0]           mem [MEM_DEPTH];

   logic [1:0]            state_q, state_d;
   logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
   logic [ADDR_WIDTH:0]   wr_count_q, wr_count_d;
   logic                  busy_q, done_q;
   logic [15:0]           rd_data_q;
   logic                  we_s;
   logic                  rd_in_range_s;

   // Next-state, write-enable and write-pointer computation
   always_comb begin
      state_d    = state_q;
      wr_addr_d  = wr_addr_q;
      wr_count_d = wr_count_q;
      we_s       = 1'b0;
      case (state_q)
         IDLE, DONE: begin
            // A strobe coinciding with start is not captured.
            if (start) begin
               state_d    = CAPTURE;
               wr_addr_d  = {ADDR_WIDTH{1'b0}};
               wr_count_d = {(ADDR_WIDTH + 1){1'b0}};
            end else begin
               state_d    = state_q;
            end
         end
         CAPTURE: begin
            // A strobe coinciding with abort is still written.
            we_s = valid_in;
            if (valid_in) begin
               wr_count_d = wr_count_q + CNT_ONE;
               // Pointer parks on the last slot instead of wrapping.
               if (wr_addr_q == ADDR_LAST) begin
                  wr_addr_d = wr_addr_q;
               end else begin
                  wr_addr_d = wr_addr_q + ADDR_ONE;
               end
            end else begin
               wr_count_d = wr_count_q;
            end
            if (abort) begin
               state_d = IDLE;
            end else if (valid_in && (wr_addr_q == ADDR_LAST)) begin
               state_d = DONE;
            end else begin
               state_d = CAPTURE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Control state, write pointer, count and decoded status flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         wr_addr_q  <= {ADDR_WIDTH{1'b0}};
         wr_count_q <= {(ADDR_WIDTH + 1){1'b0}};
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_addr_q  <= wr_addr_d;
         wr_count_q <= wr_count_d;
         busy_q     <= (state_d == CAPTURE);
         done_q     <= (state_d == DONE);
      end
   end

   // RAM write port; contents deliberately survive reset
   always_ff @(posedge clk) begin
      if (we_s) begin
         mem[wr_addr_q] <= sample_in;
      end
   end

   assign rd_in_range_s = ({1'b0, rd_addr} < DEPTH_CNT);

   // Registered read port; the old word is returned on a same-address write
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data_q <= 16'h0000;
      end else if (rd_in_range_s) begin
         rd_data_q <= mem[rd_addr];
      end else begin
         rd_data_q <= 16'h0000;
      end
   end

   assign rd_data  = rd_data_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign wr_count = wr_count_q;

`ifdef BAND_CAPTURE_PEAK_EN
   logic [15:0] peak_q, peak_d;
   logic [15:0] sample_abs_s;

   // Magnitude of a 16-bit two's-complement value; -32768 saturates to 32767
   function automatic logic [15:0] abs_sat(input logic [15:0] s);
      if (s == 16'h8000) begin
         return 16'h7FFF;
      end else if (s[15]) begin
         return (~s) + 16'h0001;
      end else begin
         return s;
      end
   endfunction

   assign sample_abs_s = abs_sat(sample_in);

   // Peak tracker: cleared on start, updated alongside each write
   always_comb begin
      peak_d = peak_q;
      if ((state_q != CAPTURE) && start) begin
         peak_d = 16'h0000;
      end else if (we_s && (sample_abs_s > peak_q)) begin
         peak_d = sample_abs_s;
      end else begin
         peak_d = peak_q;
      end
   end

   // Peak register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         peak_q <= 16'h0000;
      end else begin
         peak_q <= peak_d;
      end
   end

   assign peak_abs = peak_q;
`endif

endmodule

// File: tb/tb_band_capture.sv
// Self-checking bench for band_capture with MEM_DEPTH=8.
module tb_band_capture;

   localparam int DEPTH = 8;
   localparam int AW    = 3;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic          abort;
   logic [15:0]   sample_in;
   logic          valid_in;
   logic [AW-1:0] rd_addr;
   logic [15:0]   rd_data;
   logic          busy;
   logic          done;
   logic [AW:0]   wr_count;
`ifdef BAND_CAPTURE_PEAK_EN
   logic [15:0]   peak_abs;
`endif

   int pass_cnt  = 0;
   int total_cnt = 0;

   typedef struct {
      logic [AW-1:0] addr;
      logic [15:0]   data;
   } rd_exp_t;
   rd_exp_t sb[$];

   typedef struct {
      logic [15:0] sample;
      logic [15:0] expect_val;
   } vec_t;

   band_capture #(.MEM_DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .abort     (abort),
      .sample_in (sample_in),
      .valid_in  (valid_in),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .busy      (busy),
      .done      (done),
      .wr_count  (wr_count)
`ifdef BAND_CAPTURE_PEAK_EN
      ,
      .peak_abs  (peak_abs)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) begin
         pass_cnt++;
      end else begin
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // All tasks start and end 1 time unit after a rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic pulse_abort();
      abort = 1'b1;
      step();
      abort = 1'b0;
   endtask

   task automatic wr(input logic [15:0] s);
      valid_in  = 1'b1;
      sample_in = s;
      step();
      valid_in  = 1'b0;
   endtask

   task automatic pop_check();
      rd_exp_t e;
      if (sb.size() == 0) begin
         total_cnt++;
         $display("FAIL scoreboard: empty, got 0x%0h", rd_data);
      end else begin
         e = sb.pop_front();
         check($sformatf("rd_data[%0d]", e.addr), {16'h0000, rd_data}, {16'h0000, e.data});
      end
   endtask

   // Read one address; optionally write a sample in the same cycle.
   task automatic rd(input logic [AW-1:0] a, input logic [15:0] e,
                     input logic wr_same = 1'b0, input logic [15:0] s = 16'h0000);
      rd_exp_t x;
      x.addr    = a;
      x.data    = e;
      rd_addr   = a;
      valid_in  = wr_same;
      sample_in = s;
      sb.push_back(x);
      step();
      valid_in  = 1'b0;
      pop_check();
   endtask

   initial begin
      vec_t v1[DEPTH];
      vec_t vp[4];
      for (int i = 0; i < DEPTH; i++) begin
         v1[i].sample     = 16'(i + 1);
         v1[i].expect_val = 16'(i + 1);
      end
      vp[0] = '{16'hFFFB, 16'd5};
      vp[1] = '{16'd300,  16'd300};
      vp[2] = '{16'h8000, 16'd32767};
      vp[3] = '{16'd12,   16'd32767};

      rst_n = 1'b0; start = 1'b0; abort = 1'b0;
      sample_in = 16'h0000; valid_in = 1'b0; rd_addr = 3'd0;
      repeat (2) @(posedge clk);
      #1;
      check("reset busy", {31'd0, busy}, 32'd0);
      check("reset done", {31'd0, done}, 32'd0);
      check("reset wr_count", {28'd0, wr_count}, 32'd0);
      check("reset rd_data", {16'd0, rd_data}, 32'd0);
      rst_n = 1'b1;
      step();

      // Full capture with sparse strobes
      pulse_start();
      check("s1 busy after start", {31'd0, busy}, 32'd1);
      check("s1 wr_count after start", {28'd0, wr_count}, 32'd0);
      for (int i = 0; i < DEPTH; i++) begin
         repeat (99) step();
         wr(v1[i].sample);
         check("s1 busy", {31'd0, busy}, (i < DEPTH - 1) ? 32'd1 : 32'd0);
         check("s1 done", {31'd0, done}, (i < DEPTH - 1) ? 32'd0 : 32'd1);
         check("s1 wr_count", {28'd0, wr_count}, 32'(i + 1));
      end
      for (int i = 0; i < DEPTH; i++) begin
         rd(3'(i), v1[i].expect_val);
      end

      // Start with coincident strobe; start ignored in CAPTURE; abort beats start
      start = 1'b1; valid_in = 1'b1; sample_in = 16'h7FFF;
      step();
      start = 1'b0; valid_in = 1'b0;
      check("s2 done cleared", {31'd0, done}, 32'd0);
      check("s2 wr_count", {28'd0, wr_count}, 32'd0);
      wr(16'h0011);
      wr(16'h0022);
      check("s2 wr_count 2", {28'd0, wr_count}, 32'd2);
      pulse_start();
      check("s2 start ignored", {28'd0, wr_count}, 32'd2);
      rd(3'd0, 16'h0011);
      rd(3'd1, 16'h0022);
      rd(3'd2, 16'h0003);
      abort = 1'b1; start = 1'b1;
      step();
      abort = 1'b0; start = 1'b0;
      check("s2 abort prio busy", {31'd0, busy}, 32'd0);
      check("s2 abort keeps count", {28'd0, wr_count}, 32'd2);
      pulse_abort();
      check("s2 abort idle busy", {31'd0, busy}, 32'd0);

      // Abort with coincident strobe; strobes ignored in IDLE
      pulse_start();
      wr(16'h00A1); wr(16'h00A2); wr(16'h00A3);
      abort = 1'b1; valid_in = 1'b1; sample_in = 16'hBEEF;
      step();
      abort = 1'b0; valid_in = 1'b0;
      check("s3 busy", {31'd0, busy}, 32'd0);
      check("s3 done", {31'd0, done}, 32'd0);
      check("s3 wr_count", {28'd0, wr_count}, 32'd4);
      rd(3'd3, 16'hBEEF);
      wr(16'h1234);
      check("s3 idle strobe count", {28'd0, wr_count}, 32'd4);
      rd(3'd4, 16'h0005);

      // Full, extra strobes in DONE, then restart; read-first collision
      pulse_start();
      for (int i = 0; i < DEPTH; i++) wr(16'h0100 + 16'(i));
      check("s4 done", {31'd0, done}, 32'd1);
      check("s4 wr_count", {28'd0, wr_count}, 32'd8);
      for (int i = 0; i < 5; i++) wr(16'hDEAD);
      check("s4 count held", {28'd0, wr_count}, 32'd8);
      rd(3'd7, 16'h0107);
      rd(3'd0, 16'h0100);
      pulse_abort();
      check("s4 abort in done", {31'd0, done}, 32'd1);
      pulse_start();
      check("s4 restart done", {31'd0, done}, 32'd0);
      check("s4 restart busy", {31'd0, busy}, 32'd1);
      check("s4 restart count", {28'd0, wr_count}, 32'd0);
      rd(3'd5, 16'h0105);
      rd(3'd0, 16'h0100, 1'b1, 16'h5555);
      rd(3'd0, 16'h5555);
      check("s4 count after write", {28'd0, wr_count}, 32'd1);

      // Reset mid-capture
      pulse_abort();
      pulse_start();
      for (int i = 1; i <= 5; i++) wr(16'h0030 + 16'(i));
      rd(3'd4, 16'h0035);
      rst_n = 1'b0;
      #1;
      check("s5 rst busy", {31'd0, busy}, 32'd0);
      check("s5 rst done", {31'd0, done}, 32'd0);
      check("s5 rst wr_count", {28'd0, wr_count}, 32'd0);
      check("s5 rst rd_data", {16'd0, rd_data}, 32'd0);
`ifdef BAND_CAPTURE_PEAK_EN
      check("s5 rst peak", {16'd0, peak_abs}, 32'd0);
`endif
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      step();
      check("s5 idle after rst", {31'd0, busy}, 32'd0);
      rd(3'd4, 16'h0035);
      pulse_start();
      wr(16'h0777);
      rd(3'd0, 16'h0777);
      rd(3'd1, 16'h0032);
      check("s5 wr_count", {28'd0, wr_count}, 32'd1);

`ifdef BAND_CAPTURE_PEAK_EN
      check("p peak before restart", {16'd0, peak_abs}, 32'h777);
      pulse_abort();
      pulse_start();
      check("p peak cleared", {16'd0, peak_abs}, 32'd0);
      for (int i = 0; i < 4; i++) begin
         wr(vp[i].sample);
         check($sformatf("p peak %0d", i), {16'd0, peak_abs}, {16'd0, vp[i].expect_val});
      end
`endif

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
